uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered transmit front-end that sits directly upstream of the simple UART's data-register port. It absorbs CPU byte writes into a synchronous FIFO and drains them into the UART one at a time. The CPU stalls only when the FIFO is full, instead of on every byte while the UART is shifting. Its downstream port drives the UART's reg_dat_we / reg_dat_di and observes the UART's reg_dat_wait.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries of 8 bits); legal range 1..8.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
reg_dat_we  input  1  CPU write strobe for one TX byte.
reg_dat_di  input  32  CPU write data; only [7:0] is stored.
reg_dat_wait  output  1  CPU stall: high when reg_dat_we is high and the FIFO is full.
reg_sta_do  output  32  status: [8:0] fill count, [16] empty, [17] full, [18] busy (FSM in SEND); other bits 0.
flush  input  1  synchronous clear of FIFO contents and drain FSM.
uart_dat_we  output  1  write strobe toward the UART data register.
uart_dat_di  output  32  {24'b0, head byte} toward the UART.
uart_dat_wait  input  1  UART stall; a transfer completes on a cycle with uart_dat_we high and uart_dat_wait low.

Behaviour:
- Clock is clk, reset is reset; reset is asynchronous and active-high.
- Reset values: pointers 0, count 0, FSM IDLE, uart_dat_we 0, uart_dat_di 0. Consequently reg_sta_do = 0x00010000 (empty) and reg_dat_wait = 0.
- Count width is DEPTH_LOG2+1. Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Push: occurs when reg_dat_we && !full && !flush. It writes reg_dat_di[7:0] at wptr and increments wptr.
- reg_dat_wait = reg_dat_we && full. It is combinational, so the CPU holds its write until space frees.
- Full-cycle rule: a push is refused while full, even if a pop happens in the same cycle. The CPU retries the next cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Drain FSM has two states:
  - IDLE: uart_dat_we = 0. If the FIFO is non-empty, go to SEND, loading uart_dat_di from the head entry.
  - SEND: uart_dat_we = 1 and uart_dat_di is held stable. On !uart_dat_wait, pop (rptr+1, count-1). Then:
    - if the FIFO still holds another byte, stay in SEND and load the next head;
    - otherwise go to IDLE.
  - Outputs are registered. uart_dat_we is deasserted in the cycle after the final accept, so no duplicate writes occur.
- Latency: a push into an empty FIFO while IDLE gives uart_dat_we = 1 two cycles later (count update, then FSM).
- Back-to-back drain: while the UART accepts every cycle, one byte leaves per cycle.
- Flush has priority over push and pop in the same cycle:
  - pointers and count go to 0, FSM goes to IDLE, uart_dat_we goes to 0 the next cycle;
  - a byte accepted by the UART in the flush cycle is not replayed.
- reset asserted mid-transfer: uart_dat_we drops immediately (asynchronous) and all contents are lost.
- busy = (state == SEND).

Optional Feature:
Macro UART_TX_FIFO_IRQ_EN.
- Defined: adds output tx_irq (1 bit). It is a registered one-cycle pulse when the FIFO transitions from non-empty to empty through a pop (not through flush or reset). reg_sta_do[19] is a sticky copy of that pulse, cleared by a write with reg_dat_di[31] = 1 while reg_dat_we is high; no byte is pushed on that write.
- Not defined: no tx_irq port, bit 19 reads 0, and reg_dat_di[31] is ignored.

Decomposition:
- Package uart_tx_fifo_pkg holds:
  - state enum {IDLE, SEND};
  - status bit-index constants STA_EMPTY=16, STA_FULL=17, STA_BUSY=18, STA_IRQ=19;
  - localparam DEPTH = 1 << DEPTH_LOG2.
- One sub-module, uart_tx_fifo_mem: a DEPTH×8 register array with write port (we, waddr, wdata) and asynchronous read (raddr → rdata). Pointers and count stay in the parent.

Test Plan:
- Reset then write 0x41 with uart_dat_wait = 0 → uart_dat_we high exactly 2 cycles later with uart_dat_di = 0x41 for one cycle; reg_sta_do returns to 0x00010000.
- Hold uart_dat_wait = 1 and write 16 bytes 0x00..0x0F, then attempt a 17th (0x10) → reg_dat_wait = 1, count = 16, full = 1; release wait → bytes 0x00..0x0F then 0x10 are emitted in order, with no duplicates or drops.
- Write a byte in the same cycle the UART accepts a byte at count = 5 → count stays 5 and order is preserved.
- At full, push and pop in the same cycle → push refused (reg_dat_wait = 1) and count becomes 15; the next-cycle retry succeeds.
- Load 8 bytes, pulse flush while in SEND with uart_dat_wait = 1 → next cycle uart_dat_we = 0, count = 0, empty = 1; a later write of 0x55 drains normally.
- (UART_TX_FIFO_IRQ_EN) Drain 3 bytes → one tx_irq pulse and status bit 19 = 1; write with reg_dat_di[31] = 1 → bit 19 = 0 and count unchanged; flush of a non-empty FIFO → no pulse.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmit front-end.
// No logic of its own; the sizing values here are defaults only.
// The fifo top and its storage array import this package.
package uart_tx_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  localparam int DATA_W          = 8;
  localparam int STA_CNT_W       = 9;
  localparam int STA_EMPTY       = 16;
  localparam int STA_FULL        = 17;
  localparam int STA_BUSY        = 18;
  localparam int STA_IRQ         = 19;
  localparam int DEPTH_LOG2_DFLT = 4;
  localparam int DEPTH           = 1 << DEPTH_LOG2_DFLT;

  // Entry count for a given log2 depth.
  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage array for the transmit FIFO: one write port, one asynchronous read port.
// Latency: a write lands on the rising edge; a read is combinational from raddr_i.
// Backpressure: none. The parent owns the pointers and guarantees it never overwrites live data.
module uart_tx_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DFLT
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [depth_of(DEPTH_LOG2)];

  // Store the pushed byte. The data path needs no reset because the count qualifies it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART TX front-end: the CPU pushes bytes into a FIFO and an FSM drains them into the UART.
// Latency: a push into an empty FIFO drives uart_dat_we two cycles later; after that, one byte per cycle.
// Backpressure: reg_dat_wait stalls the CPU only when the FIFO is full. uart_dat_wait holds the head byte.
// Optional: define UART_TX_FIFO_IRQ_EN to add the tx_irq drained pulse and sticky status bit 19.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_dat_we,
  input  logic [31:0] reg_dat_di,
  output logic        reg_dat_wait,
  output logic [31:0] reg_sta_do,
  input  logic        flush,
  output logic        uart_dat_we,
  output logic [31:0] uart_dat_di,
  input  logic        uart_dat_wait
`ifdef UART_TX_FIFO_IRQ_EN
  ,
  output logic        tx_irq
`endif
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(depth_of(DEPTH_LOG2));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  raddr;
  logic [DATA_W-1:0] head_byte;
  tx_state_e         state_q;
  logic              uart_we_q;
  logic [DATA_W-1:0] uart_byte_q;
  logic              full, empty, clr_wr, push, pop;

`ifdef UART_TX_FIFO_IRQ_EN
  // Bit 31 turns a write into an interrupt-clear command, and no byte is stored.
  assign clr_wr = reg_dat_we && reg_dat_di[31];
  logic unused_di;
  assign unused_di = ^reg_dat_di[30:8];
`else
  assign clr_wr = 1'b0;
  logic unused_di;
  assign unused_di = ^reg_dat_di[31:8];
`endif

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push         = reg_dat_we && !full && !flush && !clr_wr;
  // SEND is only entered with data present, so a pop never underflows.
  assign pop          = (state_q == SEND) && !uart_dat_wait && !flush;
  assign reg_dat_wait = reg_dat_we && full;

  // When popping, prefetch the entry behind the head so SEND can reload without a bubble.
  assign raddr = pop ? (rptr_q + PTR_ONE) : rptr_q;

  uart_tx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (reg_dat_di[DATA_W-1:0]),
    .raddr_i (raddr),
    .rdata_o (head_byte)
  );

  // Next pointer and count values. Flush overrides any push or pop in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Drain FSM with registered strobe and data. The strobe drops in the cycle after the final accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      uart_we_q   <= 1'b0;
      uart_byte_q <= '0;
    end else if (flush) begin
      state_q   <= IDLE;
      uart_we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q     <= SEND;
            uart_we_q   <= 1'b1;
            uart_byte_q <= head_byte;
          end
        end
        SEND: begin
          if (!uart_dat_wait) begin
            if (count_q > CNT_ONE) begin
              uart_byte_q <= head_byte;
            end else begin
              state_q   <= IDLE;
              uart_we_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          uart_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign uart_dat_we = uart_we_q;
  assign uart_dat_di = {24'h0, uart_byte_q};

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q, irq_sticky_q, irq_set;

  // The FIFO empties through a pop only when the last byte leaves and nothing replaces it.
  assign irq_set = pop && !push && (count_q == CNT_ONE);

  // One-cycle drained pulse and its sticky copy. A new event beats a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q        <= 1'b0;
      irq_sticky_q <= 1'b0;
    end else begin
      irq_q <= irq_set;
      if (irq_set)     irq_sticky_q <= 1'b1;
      else if (clr_wr) irq_sticky_q <= 1'b0;
    end
  end

  assign tx_irq = irq_q;
`endif

  // Status word: fill count, empty, full, busy and the optional sticky interrupt.
  always_comb begin
    reg_sta_do                  = '0;
    reg_sta_do[STA_CNT_W-1:0]   = STA_CNT_W'(count_q);
    reg_sta_do[STA_EMPTY]       = empty;
    reg_sta_do[STA_FULL]        = full;
    reg_sta_do[STA_BUSY]        = (state_q == SEND);
`ifdef UART_TX_FIFO_IRQ_EN
    reg_sta_do[STA_IRQ]         = irq_sticky_q;
`endif
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences, random traffic.
// A queue-based model predicts every edge from the negative clock edge.
// Covers the UART_TX_FIFO_IRQ_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam logic [31:0] STA_MASK = 32'hFFF7_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_dat_we = 1'b0;
  logic [31:0] reg_dat_di = 32'h0;
  logic        flush = 1'b0;
  logic        uart_dat_wait = 1'b0;
  logic        reg_dat_wait;
  logic [31:0] reg_sta_do;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
`ifdef UART_TX_FIFO_IRQ_EN
  logic        tx_irq;
  logic        exp_irq = 1'b0;
  logic        exp_sticky = 1'b0;
  int          irq_pulses = 0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_dat_we    (reg_dat_we),
    .reg_dat_di    (reg_dat_di),
    .reg_dat_wait  (reg_dat_wait),
    .reg_sta_do    (reg_sta_do),
    .flush         (flush),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait)
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    .tx_irq        (tx_irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the byte queue as the FIFO should hold it, and the UART's accepted stream.
  logic [7:0] model_q[$];
  logic [7:0] emitted[$];
  int         sz;
  logic       full_m, accept, clr, push_m;

  always @(negedge clk) begin
    if (reset) begin
      model_q.delete();
`ifdef UART_TX_FIFO_IRQ_EN
      exp_irq    = 1'b0;
      exp_sticky = 1'b0;
`endif
    end else begin
      sz     = model_q.size();
      full_m = (sz == DEPTH);
      chk("mon_count", 32'(reg_sta_do[8:0]), 32'(sz));
      chk("mon_empty", 32'(reg_sta_do[16]), 32'(sz == 0));
      chk("mon_full", 32'(reg_sta_do[17]), 32'(full_m));
      chk("mon_wait", 32'(reg_dat_wait), 32'(reg_dat_we && full_m));
`ifdef UART_TX_FIFO_IRQ_EN
      chk("mon_zero_bits", 32'({reg_sta_do[31:20], reg_sta_do[15:9]}), 32'h0);
      chk("mon_irq", 32'(tx_irq), 32'(exp_irq));
      chk("mon_sticky", 32'(reg_sta_do[19]), 32'(exp_sticky));
      if (tx_irq) irq_pulses++;
      clr = reg_dat_we && reg_dat_di[31];
`else
      chk("mon_zero_bits", 32'({reg_sta_do[31:19], reg_sta_do[15:9]}), 32'h0);
      clr = 1'b0;
`endif
      accept = uart_dat_we && !uart_dat_wait;
      push_m = reg_dat_we && !full_m && !flush && !clr;
      if (accept) begin
        emitted.push_back(uart_dat_di[7:0]);
        chk("mon_udi_hi", 32'(uart_dat_di[31:8]), 32'h0);
        if (sz == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_spurious: got byte 0x%0h expected no transfer", uart_dat_di[7:0]);
        end else begin
          chk("mon_order", 32'(uart_dat_di[7:0]), 32'(model_q.pop_front()));
        end
      end
      if (flush) model_q.delete();
      else if (push_m) model_q.push_back(reg_dat_di[7:0]);
`ifdef UART_TX_FIFO_IRQ_EN
      exp_irq = !flush && accept && (sz == 1) && !push_m;
      if (exp_irq) exp_sticky = 1'b1;
      else if (clr) exp_sticky = 1'b0;
`endif
    end
  end

  task automatic do_reset();
    reg_dat_we    = 1'b0;
    reg_dat_di    = 32'h0;
    flush         = 1'b0;
    uart_dat_wait = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      reg_dat_we = 1'b1;
      reg_dat_di = 32'(base + 8'(i));
      tick();
    end
    reg_dat_we = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    reg_dat_we    = 1'b0;
    uart_dat_wait = 1'b0;
    flush         = 1'b0;
    while ((model_q.size() != 0 || uart_dat_we) && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_left"}, 32'(model_q.size()), 32'h0);
    chk({name, "_uwe"}, 32'(uart_dat_we), 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] di;
    logic        uwait;
    logic        fl;
    logic        exp_wait;
    logic [31:0] exp_sta;
    logic        exp_uwe;
    logic [7:0]  exp_udi;
  } vec_t;

  vec_t vec [12];

  initial begin
    // we, di, uart_wait, flush | wait, status after edge, uart_we, uart byte
    vec[0]  = '{1'b1, 32'h41, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 8'h00};
    vec[1]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0004_0001, 1'b1, 8'h41};
    vec[2]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 8'h00};
    vec[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 8'h00};
    vec[4]  = '{1'b1, 32'h42, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 8'h00};
    vec[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h0004_0001, 1'b1, 8'h42};
    vec[6]  = '{1'b1, 32'h43, 1'b1, 1'b0, 1'b0, 32'h0004_0002, 1'b1, 8'h42};
    vec[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0004_0001, 1'b1, 8'h43};
    vec[8]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 8'h00};
    vec[9]  = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 8'h00};
    vec[10] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 8'h00};
    vec[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 8'h00};

    // Reset state
    tick();
    chk("rst_sta", reg_sta_do, 32'h0001_0000);
    chk("rst_wait", 32'(reg_dat_wait), 32'h0);
    chk("rst_uwe", 32'(uart_dat_we), 32'h0);
    chk("rst_udi", uart_dat_di, 32'h0);
    reset = 1'b0;
    tick();

    // Vector table: single-byte latency, held transfer, pipelined reload, flush while idle
    for (int r = 0; r < 12; r++) begin
      reg_dat_we    = vec[r].we;
      reg_dat_di    = vec[r].di;
      uart_dat_wait = vec[r].uwait;
      flush         = vec[r].fl;
      #1;
      chk("tbl_wait", 32'(reg_dat_wait), 32'(vec[r].exp_wait));
      tick();
      chk("tbl_sta", reg_sta_do & STA_MASK, vec[r].exp_sta);
      chk("tbl_uwe", 32'(uart_dat_we), 32'(vec[r].exp_uwe));
      if (vec[r].exp_uwe) chk("tbl_udi", uart_dat_di, {24'h0, vec[r].exp_udi});
    end

    // Fill to full, then overflow stall, the full-cycle refusal, the retry and the drain order
    do_reset();
    emitted.delete();
    uart_dat_wait = 1'b1;
    push_bytes(8'h00, 16);
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h10;
    #1;
    chk("fill_wait", 32'(reg_dat_wait), 32'h1);
    chk("fill_count", 32'(reg_sta_do[8:0]), 32'd16);
    chk("fill_full", 32'(reg_sta_do[17]), 32'h1);
    tick();
    chk("fill_hold_count", 32'(reg_sta_do[8:0]), 32'd16);
    uart_dat_wait = 1'b0;
    #1;
    chk("fc_refuse", 32'(reg_dat_wait), 32'h1);
    tick();
    chk("fc_count", 32'(reg_sta_do[8:0]), 32'd15);
    chk("fc_wait_low", 32'(reg_dat_wait), 32'h0);
    tick();
    chk("fc_retry_count", 32'(reg_sta_do[8:0]), 32'd15);
    reg_dat_we = 1'b0;
    drain("fill_drain", 40);
    chk("fill_emitted_n", 32'(emitted.size()), 32'd17);
    for (int i = 0; i < emitted.size() && i < 17; i++)
      chk("fill_order", 32'(emitted[i]), 32'(i < 16 ? i : 16));

    // Push and pop together at a fill count of 5
    do_reset();
    emitted.delete();
    uart_dat_wait = 1'b1;
    push_bytes(8'hA0, 5);
    tick();
    chk("c5_pre_count", 32'(reg_sta_do[8:0]), 32'd5);
    reg_dat_we    = 1'b1;
    reg_dat_di    = 32'hA5;
    uart_dat_wait = 1'b0;
    tick();
    reg_dat_we    = 1'b0;
    uart_dat_wait = 1'b1;
    #1;
    chk("c5_count", 32'(reg_sta_do[8:0]), 32'd5);
    drain("c5_drain", 20);
    chk("c5_emitted_n", 32'(emitted.size()), 32'd6);
    for (int i = 0; i < emitted.size() && i < 6; i++)
      chk("c5_order", 32'(emitted[i]), 32'(8'hA0 + 8'(i)));

    // Flush during a stalled SEND, then normal operation resumes
    do_reset();
    uart_dat_wait = 1'b1;
    push_bytes(8'h60, 8);
    tick();
    chk("fl_busy", 32'(reg_sta_do[18]), 32'h1);
    chk("fl_pre_uwe", 32'(uart_dat_we), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_uwe", 32'(uart_dat_we), 32'h0);
    chk("fl_count", 32'(reg_sta_do[8:0]), 32'h0);
    chk("fl_empty", 32'(reg_sta_do[16]), 32'h1);
    emitted.delete();
    tick();
    chk("fl_idle_uwe", 32'(uart_dat_we), 32'h0);
    reg_dat_we    = 1'b1;
    reg_dat_di    = 32'h55;
    uart_dat_wait = 1'b0;
    tick();
    reg_dat_we = 1'b0;
    drain("fl_drain", 10);
    chk("fl_emitted_n", 32'(emitted.size()), 32'd1);
    if (emitted.size() > 0) chk("fl_byte", 32'(emitted[0]), 32'h55);

    // Asynchronous reset mid-transfer drops the strobe immediately
    do_reset();
    uart_dat_wait = 1'b1;
    push_bytes(8'h70, 2);
    tick();
    chk("ar_pre_uwe", 32'(uart_dat_we), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_uwe", 32'(uart_dat_we), 32'h0);
    chk("ar_sta", reg_sta_do, 32'h0001_0000);
    tick();
    reset = 1'b0;
    tick();
    chk("ar_after_sta", reg_sta_do, 32'h0001_0000);

`ifdef UART_TX_FIFO_IRQ_EN
    // Drained pulse, sticky bit, clear write and flush without a pulse
    do_reset();
    irq_pulses = 0;
    push_bytes(8'h30, 3);
    drain("irq_drain", 20);
    tick();
    tick();
    chk("irq_pulses", 32'(irq_pulses), 32'd1);
    chk("irq_sticky", 32'(reg_sta_do[19]), 32'h1);
    uart_dat_wait = 1'b1;
    push_bytes(8'h38, 2);
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h8000_00AA;
    tick();
    reg_dat_we = 1'b0;
    #1;
    chk("irq_clr", 32'(reg_sta_do[19]), 32'h0);
    chk("irq_clr_count", 32'(reg_sta_do[8:0]), 32'd2);
    irq_pulses = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    chk("irq_flush_nopulse", 32'(irq_pulses), 32'h0);
`endif

    // Random traffic against the model: a heavy-stall half, then a light-stall half
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reg_dat_we    = ($urandom_range(0, 99) < 45);
      reg_dat_di    = $urandom();
      uart_dat_wait = ($urandom_range(0, 99) < (i < 1500 ? 70 : 20));
      flush         = ($urandom_range(0, 99) < 2);
      tick();
    end
    drain("rnd_drain", 40);
    chk("rnd_final_sta", reg_sta_do & STA_MASK, 32'h0001_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1 ms");
    $fatal(1);
  end

endmodule
